// File: rtl/carry_ripple_adder_if.sv
// rtl/carry_ripple_adder_if.sv - operand/result bundle for the ripple-carry adder
interface carry_ripple_adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             overflow_o;

    // Operand source: drives operands, observes registered results
    modport master (
        output add1_i,
        output add2_i,
        input  sum_o,
        input  carry_o,
        input  overflow_o
    );

    // Adder side: consumes operands, produces registered results
    modport slave (
        input  add1_i,
        input  add2_i,
        output sum_o,
        output carry_o,
        output overflow_o
    );
endinterface

// File: rtl/carry_ripple_adder.sv
// rtl/carry_ripple_adder.sv - registered signed adder built from a ripple chain of full adders
module carry_ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    carry_ripple_adder_if.slave     bus
);
    // Carry chain: w_c[0] is the constant-zero carry-in, w_c[WIDTH] the carry-out.
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;

    assign w_c[0] = 1'b0;

    // One full adder per bit; carry ripples strictly from bit i to bit i+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_a;
        logic w_b;
        assign w_a        = bus.add1_i[i];
        assign w_b        = bus.add2_i[i];
        assign w_s[i]     = w_a ^ w_b ^ w_c[i];
        assign w_c[i + 1] = (w_a & w_b) | (w_a & w_c[i]) | (w_b & w_c[i]);
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH - 1];

    // Output register; reset clears results immediately and drops any pending sum.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_sum   <= w_s;
            r_carry <= w_c[WIDTH];
            r_ovf   <= w_ovf;
        end
    end

    assign bus.sum_o      = r_sum;
    assign bus.carry_o    = r_carry;
    assign bus.overflow_o = r_ovf;
endmodule

// File: tb/tb_carry_ripple_adder.sv
// tb/tb_carry_ripple_adder.sv - scoreboard bench for carry_ripple_adder
module tb_carry_ripple_adder;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t last_exp;

    always #5 clk_i = ~clk_i;

    carry_ripple_adder_if #(.WIDTH(WIDTH)) bus ();

    carry_ripple_adder #(.WIDTH(WIDTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] full;
        exp_t e;
        full    = {1'b0, a} + {1'b0, b};
        e.sum   = full[WIDTH-1:0];
        e.carry = full[WIDTH];
        e.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check_val({tag, ".sum"},   bus.sum_o,                     e.sum);
        check_val({tag, ".carry"}, {{(WIDTH-1){1'b0}}, bus.carry_o},    {{(WIDTH-1){1'b0}}, e.carry});
        check_val({tag, ".ovf"},   {{(WIDTH-1){1'b0}}, bus.overflow_o}, {{(WIDTH-1){1'b0}}, e.ovf});
    endtask

    // Drive one operand pair at the falling edge, compare after the next rising
    // edge, then disturb the operands mid-cycle and confirm the outputs hold.
    task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit release_rst, input string tag);
        bit in_reset;
        @(negedge clk_i);
        bus.add1_i = a;
        bus.add2_i = b;
        if (release_rst) rst_i = 1'b0;
        in_reset = rst_i;
        if (!in_reset) sb.push_back(model(a, b));
        @(posedge clk_i);
        #1;
        if (in_reset) begin
            last_exp = '0;
        end else if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
            last_exp = '0;
        end else begin
            last_exp = sb.pop_front();
        end
        check_all(tag, last_exp);
        #2;
        bus.add1_i = $urandom;
        bus.add2_i = $urandom;
        #1;
        check_all({tag, ".hold"}, last_exp);
    endtask

    initial begin
        bus.add1_i = '0;
        bus.add2_i = '0;

        // Reset takes effect without a clock edge and holds across edges.
        #2;
        bus.add1_i = 32'h1234_5678;
        bus.add2_i = 32'h7FFF_0001;
        rst_i = 1'b1;
        #1;
        check_all("rst_imm", '0);
        @(posedge clk_i);
        #1;
        check_all("rst_hold", '0);

        // First edge after release loads 13 + 7.
        apply(32'd13, 32'd7, 1'b1, "rst_release");

        // Overflow boundaries and sign mixes.
        apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "pos_ovf");
        apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "neg_ovf");
        apply(32'd51,        -32'sd55,      1'b0, "mix_neg");
        apply(32'd50,        -32'sd50,      1'b0, "mix_zero");
        apply(-32'sd256,     32'd256,       1'b0, "neg_pos_zero");
        apply(-32'sd13,      -32'sd7,       1'b0, "neg_neg");
        apply(32'd250,       32'd350,       1'b0, "large_pos");
        apply(-32'sd2000000000, -32'sd32,   1'b0, "large_neg");
        apply(32'd0,         32'd0,         1'b0, "zero");
        apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "full_ripple");

        // Back-to-back vectors with a mid-stream asynchronous reset.
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                rst_i = 1'b1;
                #1;
                check_all("mid_rst_imm", '0);
                apply($urandom, $urandom, 1'b0, "mid_rst_edge");
                apply($urandom, $urandom, 1'b1, "mid_rst_resume");
            end
            apply($urandom, $urandom, 1'b0, $sformatf("pipe%0d", i));
        end

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
